// File: rtl/spi_master_pkg.sv
// Shared SPI types and defaults: master/slave state enums and the default
// sysClk-per-half-period divide ratio.
package spi_master_pkg;

  localparam int unsigned CLK_DIV_DEFAULT = 4;

  typedef enum logic [2:0] {
    MSIdle,
    MSSetup,
    MSHigh,
    MSLow,
    MSNext,
    MSHold
  } MasterState;

  typedef enum logic [1:0] {
    SSIdle,
    SSShift,
    SSDone
  } SlaveState;

endpackage

// File: rtl/spi_master_div.sv
// SPIClkDivider: emits a one-cycle tick every CLK_DIV sysClk cycles while
// enabled. restart (or disable) forces the count back to 0 so the first tick
// after a restart lands exactly CLK_DIV cycles later.
module SPIClkDivider
  import spi_master_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic sysClk,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: wrap at LAST, hold at 0 when idle or restarted
  always_comb begin
    cnt_d = cnt_q;
    if (restart || !enable) cnt_d = '0;
    else if (cnt_q == LAST) cnt_d = '0;
    else cnt_d = cnt_q + CW'(1);
  end

  // Count register
  always_ff @(posedge sysClk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/spi_master.sv
// spi_master: mode-0 SPI byte master with /CS framing. Bytes sent with
// last=0 keep /CS low and park in MSNext awaiting the next byte; last=1
// releases /CS one half-period after the final bit.
// Optional build macro SPI_MASTER_LOOPBACK_EN: receive shifter samples the
// internal mosi instead of the miso pin (miso port still present).
module spi_master
  import spi_master_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic       sysClk,
  input  logic       reset,
  input  logic       send,
  input  logic       last,
  input  logic [7:0] tx_byte,
  output logic       ready,
  output logic       busy,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       spiClk,
  output logic       cs,
  output logic       mosi,
  input  logic       miso
);

  MasterState state_q, state_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rxsh_q, rxsh_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic [2:0] bitCnt_q, bitCnt_d;
  logic       last_q, last_d;
  logic       spiClk_q, spiClk_d;
  logic       cs_q, cs_d;
  logic       mosi_q, mosi_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tick, accept, rx_bit;

  assign ready  = (state_q == MSIdle) || (state_q == MSNext);
  assign busy   = (state_q != MSIdle);
  assign accept = ready && send;

`ifdef SPI_MASTER_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = miso;
  assign rx_bit      = mosi_q;
`else
  assign rx_bit      = miso;
`endif

  SPIClkDivider #(.CLK_DIV(CLK_DIV)) u_div (
    .sysClk (sysClk),
    .reset  (reset),
    .enable (busy),
    .restart(accept),
    .tick   (tick)
  );

  // Next-state and datapath: accepted send has priority over a pending tick
  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    rxsh_d     = rxsh_q;
    rx_byte_d  = rx_byte_q;
    bitCnt_d   = bitCnt_q;
    last_d     = last_q;
    spiClk_d   = spiClk_q;
    cs_d       = cs_q;
    mosi_d     = mosi_q;
    rx_valid_d = 1'b0;
    if (accept) begin
      cs_d     = 1'b0;
      mosi_d   = tx_byte[7];
      tx_d     = tx_byte;
      last_d   = last;
      bitCnt_d = 3'd7;
      spiClk_d = 1'b0;
      state_d  = MSSetup;
    end else if (tick) begin
      case (state_q)
        MSSetup, MSLow: begin
          spiClk_d = 1'b1;
          rxsh_d   = {rxsh_q[6:0], rx_bit};
          state_d  = MSHigh;
        end
        MSHigh: begin
          spiClk_d = 1'b0;
          if (bitCnt_q != 3'd0) begin
            bitCnt_d = bitCnt_q - 3'd1;
            mosi_d   = tx_q[bitCnt_q - 3'd1];
            state_d  = MSLow;
          end else begin
            rx_byte_d  = rxsh_q;
            rx_valid_d = 1'b1;
            state_d    = last_q ? MSHold : MSNext;
          end
        end
        MSHold: begin
          cs_d    = 1'b1;
          mosi_d  = 1'b0;
          state_d = MSIdle;
        end
        default: ;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge sysClk) begin
    if (reset) begin
      state_q    <= MSIdle;
      tx_q       <= 8'h00;
      rxsh_q     <= 8'h00;
      rx_byte_q  <= 8'h00;
      bitCnt_q   <= 3'd0;
      last_q     <= 1'b0;
      spiClk_q   <= 1'b0;
      cs_q       <= 1'b1;
      mosi_q     <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      rxsh_q     <= rxsh_d;
      rx_byte_q  <= rx_byte_d;
      bitCnt_q   <= bitCnt_d;
      last_q     <= last_d;
      spiClk_q   <= spiClk_d;
      cs_q       <= cs_d;
      mosi_q     <= mosi_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign rx_byte  = rx_byte_q;
  assign rx_valid = rx_valid_q;
  assign spiClk   = spiClk_q;
  assign cs       = cs_q;
  assign mosi     = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: CLK_DIV=4 instance with a mode-0 slave model (or an
// echo wire) on its bus, plus a CLK_DIV=2 instance for timing checks.
module tb_spi_master;

  logic sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

  logic       reset = 1'b1, send = 1'b0, last = 1'b0, miso;
  logic [7:0] tx_byte = 8'h00;
  logic       ready, busy, rx_valid, spiClk, cs, mosi;
  logic [7:0] rx_byte;

  logic       send2 = 1'b0, last2 = 1'b0, miso2;
  logic [7:0] tx2 = 8'h00;
  logic       ready2, busy2, rxv2, spiClk2, cs2, mosi2;
  logic [7:0] rxb2;

  spi_master #(.CLK_DIV(4)) u_dut (
    .sysClk(sysClk), .reset(reset), .send(send), .last(last), .tx_byte(tx_byte),
    .ready(ready), .busy(busy), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .spiClk(spiClk), .cs(cs), .mosi(mosi), .miso(miso));

  spi_master #(.CLK_DIV(2)) u_dut2 (
    .sysClk(sysClk), .reset(reset), .send(send2), .last(last2), .tx_byte(tx2),
    .ready(ready2), .busy(busy2), .rx_byte(rxb2), .rx_valid(rxv2),
    .spiClk(spiClk2), .cs(cs2), .mosi(mosi2), .miso(miso2));

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  always @(posedge sysClk) cyc++;

  // ---------------- bus monitor for the CLK_DIV=4 instance ----------------
  logic [7:0] rx_got[$];
  int         rx_cyc[$];
  int         cs_low_cnt = 0, sclk_rise_cnt = 0, cs_rise_cnt = 0;
  logic       prev_sclk = 1'b0, prev_cs = 1'b1;

  always @(negedge sysClk) begin
    if (rx_valid === 1'b1) begin rx_got.push_back(rx_byte); rx_cyc.push_back(cyc); end
    if (cs === 1'b0) cs_low_cnt++;
    if (spiClk === 1'b1 && prev_sclk === 1'b0) sclk_rise_cnt++;
    if (cs === 1'b1 && prev_cs === 1'b0) cs_rise_cnt++;
    prev_sclk = spiClk;
    prev_cs   = cs;
  end

  // ---------------- mode-0 slave model ----------------
  // Shifts resp_arr out MSB first, captures mosi on rising spiClk.
  bit         echo = 1'b1;
  logic [7:0] resp_arr [4];
  logic [7:0] slave_rx[$];
  logic [7:0] sl_sh = 8'h00;
  logic       sl_miso = 1'b0;
  int         sl_idx = 0, sl_cnt = 0;

  always @(negedge cs) begin sl_idx = 0; sl_cnt = 0; sl_miso = resp_arr[0][7]; end
  always @(posedge cs) sl_cnt = 0;
  always @(posedge spiClk) begin
    sl_sh = {sl_sh[6:0], mosi};
    sl_cnt++;
    if (sl_cnt == 8) begin slave_rx.push_back(sl_sh); sl_cnt = 0; end
  end
  always @(negedge spiClk) begin
    if (cs === 1'b0) begin
      if (sl_cnt == 0) begin
        if (sl_idx < 3) sl_idx++;
        sl_miso = resp_arr[sl_idx][7];
      end else sl_miso = resp_arr[sl_idx][7 - sl_cnt];
    end
  end

  assign miso  = echo ? mosi : sl_miso;
  assign miso2 = mosi2;

  // ---------------- helpers (stimulus only) ----------------
  task automatic clear_mon();
    rx_got.delete(); rx_cyc.delete(); slave_rx.delete();
    cs_low_cnt = 0; sclk_rise_cnt = 0; cs_rise_cnt = 0;
  endtask

  task automatic do_send(input logic [7:0] b, input logic l, output int acc);
    int n = 0;
    @(negedge sysClk);
    while (ready !== 1'b1 && n < 400) begin @(negedge sysClk); n++; end
    vectors++;
    if (ready !== 1'b1) begin miscompares++; $display("FAIL ready_timeout: ready=%b required 1", ready); end
    send = 1'b1; tx_byte = b; last = l;
    @(negedge sysClk);
    send = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 400) begin @(negedge sysClk); n++; end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL %s_idle_timeout: busy=%b required 0", tag, busy); end
  endtask

  task automatic wait_rx(input int k);
    int n = 0;
    while (rx_got.size() < k && n < 200) begin @(negedge sysClk); n++; end
    vectors++;
    if (rx_got.size() < k) begin miscompares++; $display("FAIL rx_timeout: got %0d rx pulses required %0d", rx_got.size(), k); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge sysClk);
    send = 1'b1; tx_byte = 8'hC3; last = 1'b1;   // reset must win over send
    @(negedge sysClk);
    send = 1'b0;
    vectors++; if (cs !== 1'b1)       begin miscompares++; $display("FAIL reset_cs: got %b required 1", cs); end
    vectors++; if (spiClk !== 1'b0)   begin miscompares++; $display("FAIL reset_spiClk: got %b required 0", spiClk); end
    vectors++; if (mosi !== 1'b0)     begin miscompares++; $display("FAIL reset_mosi: got %b required 0", mosi); end
    vectors++; if (busy !== 1'b0)     begin miscompares++; $display("FAIL reset_busy: got %b required 0", busy); end
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rx_valid: got %b required 0", rx_valid); end
    vectors++; if (rx_byte !== 8'h00) begin miscompares++; $display("FAIL reset_rx_byte: got %h required 00", rx_byte); end
    vectors++; if (ready !== 1'b1)    begin miscompares++; $display("FAIL reset_ready: got %b required 1", ready); end
    vectors++; if (cs2 !== 1'b1 || busy2 !== 1'b0) begin miscompares++; $display("FAIL reset_dut2: cs=%b busy=%b required 1/0", cs2, busy2); end
    reset = 1'b0;
    @(negedge sysClk);
    clear_mon();
  endtask

  task automatic test_single_byte();
    int acc;
    logic [7:0] b, got;
    echo = 1'b1;
    for (int k = 0; k < 4; k++) begin
      b = (k == 0) ? 8'hA5 : 8'($urandom);
      clear_mon();
      do_send(b, 1'b1, acc);
      wait_idle("single");
      got = (rx_got.size() > 0) ? rx_got[0] : 8'hxx;
      vectors++; if (rx_got.size() != 1) begin miscompares++; $display("FAIL single_rx_count: got %0d required 1", rx_got.size()); end
      vectors++; if (got !== b) begin miscompares++; $display("FAIL single_rx_byte: got %h required %h", got, b); end
      vectors++; if (rx_cyc.size() < 1 || rx_cyc[0] - acc != 64) begin miscompares++; $display("FAIL single_latency: got %0d required 64", (rx_cyc.size() > 0) ? rx_cyc[0] - acc : -1); end
      vectors++; if (cs_low_cnt != 68) begin miscompares++; $display("FAIL single_cs_low: got %0d cycles required 68", cs_low_cnt); end
      got = (slave_rx.size() > 0) ? slave_rx[0] : 8'hxx;
      vectors++; if (got !== b) begin miscompares++; $display("FAIL single_mosi_byte: got %h required %h", got, b); end
      vectors++; if (sclk_rise_cnt != 8 || mosi !== 1'b0) begin miscompares++; $display("FAIL single_edges_idle: rises=%0d mosi=%b required 8/0", sclk_rise_cnt, mosi); end
    end
  endtask

  task automatic test_frame();
    logic [7:0] ftx [4];
    logic [7:0] exp_rx, got;
    int acc_a [4];
    int n;
    echo = 1'b0;
    for (int f = 0; f < 2; f++) begin
      if (f == 0) begin
        n = 3;
        ftx[0] = 8'h41; ftx[1] = 8'h12; ftx[2] = 8'h00; ftx[3] = 8'h00;
        resp_arr[0] = 8'h79; resp_arr[1] = 8'h99; resp_arr[2] = 8'hE4; resp_arr[3] = 8'h00;
      end else begin
        n = 2 + int'($urandom_range(0, 2));
        for (int i = 0; i < 4; i++) begin ftx[i] = 8'($urandom); resp_arr[i] = 8'($urandom); end
      end
      clear_mon();
      for (int i = 0; i < n; i++) begin
        do_send(ftx[i], (i == n - 1), acc_a[i]);
        wait_rx(i + 1);
      end
      wait_idle("frame");
      vectors++; if (cs_rise_cnt != 1) begin miscompares++; $display("FAIL frame_cs_rises: got %0d required 1", cs_rise_cnt); end
      vectors++; if (sclk_rise_cnt != 8 * n) begin miscompares++; $display("FAIL frame_sclk_rises: got %0d required %0d", sclk_rise_cnt, 8 * n); end
      for (int i = 0; i < n; i++) begin
`ifdef SPI_MASTER_LOOPBACK_EN
        exp_rx = ftx[i];
`else
        exp_rx = resp_arr[i];
`endif
        got = (rx_got.size() > i) ? rx_got[i] : 8'hxx;
        vectors++; if (got !== exp_rx) begin miscompares++; $display("FAIL frame_rx_byte%0d: got %h required %h", i, got, exp_rx); end
        vectors++; if (rx_cyc.size() <= i || rx_cyc[i] - acc_a[i] != 64) begin miscompares++; $display("FAIL frame_latency%0d: required 64 cycles", i); end
        got = (slave_rx.size() > i) ? slave_rx[i] : 8'hxx;
        vectors++; if (got !== ftx[i]) begin miscompares++; $display("FAIL frame_mosi_byte%0d: got %h required %h", i, got, ftx[i]); end
      end
    end
    echo = 1'b1;
  endtask

  task automatic test_send_while_busy();
    int acc, n;
    logic [7:0] b, got;
    logic rdy_at_pulse;
    echo = 1'b1;
    b = 8'($urandom);
    clear_mon();
    do_send(b, 1'b1, acc);
    n = 0;
    while (spiClk !== 1'b1 && n < 50) begin @(negedge sysClk); n++; end
    rdy_at_pulse = ready;
    send = 1'b1; tx_byte = ~b; last = 1'b0;
    @(negedge sysClk);
    send = 1'b0;
    wait_idle("ignore");
    repeat (10) @(negedge sysClk);
    vectors++; if (rdy_at_pulse !== 1'b0) begin miscompares++; $display("FAIL ignore_ready: got %b required 0", rdy_at_pulse); end
    vectors++; if (rx_got.size() != 1) begin miscompares++; $display("FAIL ignore_rx_count: got %0d required 1", rx_got.size()); end
    got = (rx_got.size() > 0) ? rx_got[0] : 8'hxx;
    vectors++; if (got !== b) begin miscompares++; $display("FAIL ignore_rx_byte: got %h required %h", got, b); end
    got = (slave_rx.size() > 0) ? slave_rx[0] : 8'hxx;
    vectors++; if (got !== b || slave_rx.size() != 1) begin miscompares++; $display("FAIL ignore_mosi_byte: got %h required %h", got, b); end
    vectors++; if (rx_cyc.size() < 1 || rx_cyc[0] - acc != 64) begin miscompares++; $display("FAIL ignore_latency: required 64 cycles"); end
  endtask

  task automatic test_reset_mid();
    int acc, n;
    logic [7:0] got;
    echo = 1'b1;
    clear_mon();
    do_send(8'hFF, 1'b1, acc);
    n = 0;
    while (sclk_rise_cnt < 5 && n < 100) begin @(negedge sysClk); n++; end
    reset = 1'b1;
    @(negedge sysClk);
    reset = 1'b0;
    vectors++; if (cs !== 1'b1)       begin miscompares++; $display("FAIL abort_cs: got %b required 1", cs); end
    vectors++; if (spiClk !== 1'b0)   begin miscompares++; $display("FAIL abort_spiClk: got %b required 0", spiClk); end
    vectors++; if (busy !== 1'b0)     begin miscompares++; $display("FAIL abort_busy: got %b required 0", busy); end
    vectors++; if (rx_byte !== 8'h00 || mosi !== 1'b0) begin miscompares++; $display("FAIL abort_rx_mosi: rx=%h mosi=%b required 00/0", rx_byte, mosi); end
    repeat (80) @(negedge sysClk);
    vectors++; if (rx_got.size() != 0) begin miscompares++; $display("FAIL abort_rx_pulse: got %0d pulses required 0", rx_got.size()); end
    clear_mon();
    do_send(8'h3C, 1'b1, acc);
    wait_idle("after_abort");
    got = (rx_got.size() > 0) ? rx_got[0] : 8'hxx;
    vectors++; if (got !== 8'h3C) begin miscompares++; $display("FAIL abort_next_rx: got %h required 3c", got); end
    got = (slave_rx.size() > 0) ? slave_rx[0] : 8'hxx;
    vectors++; if (got !== 8'h3C) begin miscompares++; $display("FAIL abort_next_mosi: got %h required 3c", got); end
    vectors++; if (rx_cyc.size() < 1 || rx_cyc[0] - acc != 64) begin miscompares++; $display("FAIL abort_next_latency: required 64 cycles"); end
  endtask

  task automatic test_next_wait();
    int acc, acc2, bad;
    logic [7:0] b1, got;
    echo = 1'b1;
    b1 = 8'($urandom);
    clear_mon();
    do_send(b1, 1'b0, acc);
    wait_rx(1);
    bad = 0;
    repeat (100) begin
      @(negedge sysClk);
      if (spiClk !== 1'b0 || cs !== 1'b0 || ready !== 1'b1) bad++;
    end
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL next_wait_idle: %0d bad cycles required 0", bad); end
    do_send(8'h5A, 1'b1, acc2);
    wait_idle("next");
    got = (rx_got.size() > 1) ? rx_got[1] : 8'hxx;
    vectors++; if (got !== 8'h5A) begin miscompares++; $display("FAIL next_rx_byte: got %h required 5a", got); end
    vectors++; if (rx_cyc.size() < 2 || rx_cyc[1] - acc2 != 64) begin miscompares++; $display("FAIL next_latency: required 64 cycles"); end
    got = (slave_rx.size() > 1) ? slave_rx[1] : 8'hxx;
    vectors++; if (got !== 8'h5A || slave_rx[0] !== b1) begin miscompares++; $display("FAIL next_mosi_bytes: got %h required 5a", got); end
    vectors++; if (cs_rise_cnt != 1 || sclk_rise_cnt != 16) begin miscompares++; $display("FAIL next_frame: cs rises=%0d sclk rises=%0d required 1/16", cs_rise_cnt, sclk_rise_cnt); end
  endtask

  task automatic test_div2();
    int acc, rises, per_bad, stab_bad, last_rise, rxn, rxc, lowc, n;
    logic [7:0] b, cap, rxv;
    logic pclk, pmosi;
    for (int k = 0; k < 3; k++) begin
      b = 8'($urandom);
      @(negedge sysClk);
      n = 0;
      while (ready2 !== 1'b1 && n < 100) begin @(negedge sysClk); n++; end
      send2 = 1'b1; tx2 = b; last2 = 1'b1;
      pclk = spiClk2; pmosi = mosi2;
      @(negedge sysClk);
      send2 = 1'b0;
      acc = cyc;
      rises = 0; per_bad = 0; stab_bad = 0; last_rise = 0; rxn = 0; rxc = 0; lowc = 0; cap = 8'h00; rxv = 8'hxx;
      n = 0;
      while (busy2 === 1'b1 && n < 100) begin
        if (cs2 === 1'b0) lowc++;
        if (spiClk2 === 1'b1 && pclk === 1'b0) begin
          if (rises > 0 && cyc - last_rise != 4) per_bad++;
          if (mosi2 !== pmosi) stab_bad++;
          cap = {cap[6:0], mosi2};
          rises++;
          last_rise = cyc;
        end
        if (rxv2 === 1'b1) begin rxn++; rxc = cyc; rxv = rxb2; end
        pclk = spiClk2; pmosi = mosi2;
        @(negedge sysClk);
        n++;
      end
      vectors++; if (rises != 8 || per_bad != 0) begin miscompares++; $display("FAIL div2_period: rises=%0d bad periods=%0d required 8/0", rises, per_bad); end
      vectors++; if (stab_bad != 0) begin miscompares++; $display("FAIL div2_mosi_stable: %0d unstable edges required 0", stab_bad); end
      vectors++; if (cap !== b) begin miscompares++; $display("FAIL div2_mosi_bits: got %h required %h", cap, b); end
      vectors++; if (rxn != 1 || rxv !== b || rxc - acc != 32) begin miscompares++; $display("FAIL div2_rx: n=%0d byte=%h lat=%0d required 1/%h/32", rxn, rxv, rxc - acc, b); end
      vectors++; if (lowc != 34) begin miscompares++; $display("FAIL div2_cs_low: got %0d required 34", lowc); end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) resp_arr[i] = 8'h00;
    test_reset();
    test_single_byte();
    test_frame();
    test_send_while_busy();
    test_reset_mid();
    test_next_wait();
    test_div2();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish within bound");
    $fatal(1, "watchdog");
  end

endmodule
